mux8_scan_ctrl: RTL

- Sequencer for one 74HC151-style 8:1 mux (active-low enable, 3-bit select, single output Y).
- On a start pulse it steps the select through a masked set of channels, holding each one for a programmable settle time.
- It samples Y once per selected channel and assembles the samples into a parallel byte.
- It sits between the mux (or its RTL model) and any consumer that wants a snapshot of the eight mux data inputs, and is the sole driver of the mux's E and S.

---
 rtl/mux8_pkg.sv | 21 ++
 rtl/mux8_scan_ctrl_if.sv | 26 ++
 rtl/mux8_next_chan.sv | 25 ++
 rtl/mux8_scan_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// Shared constants for the 8:1 mux scan controller: channel count, select width,
// FSM state encodings and the settle-counter width helper.
package mux8_pkg;

  localparam int NCH = 8;
  localparam int SW  = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_HOLD = 2'd1;
  localparam state_t S_FIN  = 2'd2;

  // Counter must hold SETTLE itself; a zero-width counter is not allowed.
  function automatic int cw_of(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// Bundle of host-side and mux-side signals of the scan controller; master is the
// controller's view, slave is the view of whoever drives start/abort and the mux model.
interface mux8_scan_ctrl_if;
  import mux8_pkg::*;

  logic           start;
  logic           abort;
  logic [NCH-1:0] chan_mask;
  logic           mux_y;
  logic           mux_e;
  logic [SW-1:0]  mux_s;
  logic           busy;
  logic           done;
  logic [NCH-1:0] sample_q;

  modport master (
    input  start, abort, chan_mask, mux_y,
    output mux_e, mux_s, busy, done, sample_q
  );

  modport slave (
    output start, abort, chan_mask, mux_y,
    input  mux_e, mux_s, busy, done, sample_q
  );

endinterface

// File: rtl/mux8_next_chan.sv
// Combinational channel finder: lowest set mask bit above cur, or the lowest set
// bit overall when first is high.
module mux8_next_chan
  import mux8_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [SW-1:0]  cur,
  input  logic           first,
  output logic [SW-1:0]  idx,
  output logic           found
);

  // Scanning downward lets the last hit be the lowest qualifying index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        idx   = SW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for a 74HC151-style 8:1 mux: steps the select over a latched channel
// mask, holds each channel SETTLE+1 cycles, samples Y on the last edge, and publishes a byte.
module mux8_scan_ctrl
  import mux8_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_scan_ctrl_if.master   bus
);

  localparam int CW = cw_of(SETTLE);

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [NCH-1:0] r_mask;
  logic [NCH-1:0] r_data;
  logic [NCH-1:0] r_sample;
  logic [SW-1:0]  r_mux_s;

  logic [NCH-1:0] w_nc_mask;
  logic           w_first;
  logic [SW-1:0]  w_idx;
  logic           w_found;
  logic           w_cnt_zero;
  logic [NCH-1:0] w_data_cap;

  // In IDLE the finder looks at the incoming mask; during a scan, at the latched copy.
  assign w_first    = (r_state == S_IDLE);
  assign w_nc_mask  = w_first ? bus.chan_mask : r_mask;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_data_cap = r_data | (NCH'(bus.mux_y) << r_mux_s);

  mux8_next_chan u_next_chan (
    .mask  (w_nc_mask),
    .cur   (r_mux_s),
    .first (w_first),
    .idx   (w_idx),
    .found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = w_found ? S_HOLD : S_FIN;
        end
      end
      S_HOLD: begin
        if (bus.abort) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_zero && !w_found) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mux_e = 1'b1;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (r_state)
      S_HOLD: begin
        bus.mux_e = 1'b0;
        bus.busy  = 1'b1;
      end
      S_FIN:   bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: select, settle counter, latched mask, working bits and the published byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mask   <= '0;
      r_data   <= '0;
      r_sample <= '0;
      r_mux_s  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mask <= bus.chan_mask;
            r_data <= '0;
            r_cnt  <= CW'(SETTLE);
            if (w_found) begin
              r_mux_s <= w_idx;
            end else begin
              r_sample <= '0;
            end
          end
        end
        S_HOLD: begin
          if (!bus.abort) begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_data <= w_data_cap;
              if (w_found) begin
                r_mux_s <= w_idx;
                r_cnt   <= CW'(SETTLE);
              end else begin
                r_sample <= w_data_cap;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mux_s    = r_mux_s;
  assign bus.sample_q = r_sample;

endmodule
